// File: rtl/tick_monitor_pkg.sv
// Shared types and timebase constants for the tick monitor and its generator.
package tick_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } tm_state_t;

  localparam int unsigned TICK_PERIOD_SIM   = 5;
  localparam int unsigned TICK_PERIOD_50MHZ = 25000000;

endpackage

// File: rtl/rise_detect.sv
// Single-register rising-edge detector for slow strobes; a held-high input yields one pulse.
module rise_detect (
  input  logic clock,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic r_q;

  always_ff @(posedge clock) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= in;
  end

  assign rise = in & ~r_q;

endmodule

// File: rtl/tick_monitor.sv
// Measures edge-to-edge interval of the periodic tick and reports lock, period and early/late errors.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned EXP_PERIOD = TICK_PERIOD_SIM,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear_err,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             early_err,
  output logic             late_err,
  output logic [7:0]       err_count
);

  localparam int unsigned GC_W = $clog2(LOCK_COUNT + 1);
  // Bounds carry one extra bit so HI+1 cannot wrap at the counter width.
  localparam logic [CNT_W:0] LO  = (CNT_W+1)'(EXP_PERIOD - TOL);
  localparam logic [CNT_W:0] HI  = (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W:0] TMO = HI + 1'b1;
  localparam logic [GC_W-1:0] GC_MAX = GC_W'(LOCK_COUNT);

  logic             w_rise;
  logic [CNT_W-1:0] r_since, w_m;
  logic [CNT_W:0]   w_mx;
  tm_state_t        r_state, w_state_nx;
  logic [GC_W-1:0]  r_good, w_good_nx;
  logic [CNT_W-1:0] r_period, w_period_nx;
  logic             r_early, r_late, w_early_nx, w_late_nx, w_err;
  logic [7:0]       r_err_cnt;

  rise_detect u_rise (
    .clock (clock),
    .rst   (rst),
    .in    (tick),
    .rise  (w_rise)
  );

  assign w_m  = (&r_since) ? r_since : r_since + 1'b1;
  assign w_mx = {1'b0, w_m};

  always_comb begin
    w_state_nx  = r_state;
    w_good_nx   = r_good;
    w_period_nx = r_period;
    w_early_nx  = 1'b0;
    w_late_nx   = 1'b0;
    if (w_rise) begin
      if (r_state == SEARCH) begin
        w_state_nx = ACQUIRE;
        w_good_nx  = '0;
      end else begin
        w_period_nx = w_m;
        if (w_mx < LO) begin
          w_early_nx = 1'b1;
          w_good_nx  = '0;
          w_state_nx = ACQUIRE;
        end else if (w_mx > HI) begin
          w_late_nx  = 1'b1;
          w_good_nx  = '0;
          w_state_nx = ACQUIRE;
        end else begin
          if (r_good != GC_MAX) w_good_nx = r_good + 1'b1;
          if (w_good_nx == GC_MAX) w_state_nx = LOCKED;
        end
      end
    end else if (r_state != SEARCH && w_mx == TMO) begin
      // Missing tick: fall back to SEARCH so the timeout fires only once.
      w_late_nx  = 1'b1;
      w_good_nx  = '0;
      w_state_nx = SEARCH;
    end
  end

  assign w_err = w_early_nx | w_late_nx;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= SEARCH;
      r_good    <= '0;
      r_since   <= '0;
      r_period  <= '0;
      r_early   <= 1'b0;
      r_late    <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_nx;
      r_good   <= w_good_nx;
      r_period <= w_period_nx;
      r_early  <= w_early_nx;
      r_late   <= w_late_nx;
      if (w_rise)        r_since <= '0;
      else if (~&r_since) r_since <= r_since + 1'b1;
      if (clear_err)                      r_err_cnt <= {7'd0, w_err};
      else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign locked    = (r_state == LOCKED);
  assign period    = r_period;
  assign early_err = r_early;
  assign late_err  = r_late;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench: default instance for lock/early/late/reset, TOL=1 instance for tolerance and counter saturation.
module tb_tick_monitor;

  logic        clock = 1'b0;
  logic        rst, tick0, tick1, clr0, clr1;
  logic        locked0, early0, late0, locked1, early1, late1;
  logic [31:0] period0, period1;
  logic [7:0]  err0, err1;
  int          n_chk = 0;
  int          n_fail = 0;
  int          late_seen;

  always #5 clock = ~clock;

  tick_monitor dut0 (
    .clock(clock), .rst(rst), .tick(tick0), .clear_err(clr0),
    .locked(locked0), .period(period0), .early_err(early0),
    .late_err(late0), .err_count(err0)
  );

  tick_monitor #(.TOL(1)) dut1 (
    .clock(clock), .rst(rst), .tick(tick1), .clear_err(clr1),
    .locked(locked1), .period(period1), .early_err(early1),
    .late_err(late1), .err_count(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each call presents one cycle of tick and returns #1 after the clock edge that consumed it.
  task automatic c0(input logic t);
    tick0 = t; @(posedge clock); #1;
  endtask
  task automatic c1(input logic t);
    tick1 = t; @(posedge clock); #1;
  endtask
  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) c0(1'b0);
  endtask
  task automatic idle1(input int n);
    for (int i = 0; i < n; i++) c1(1'b0);
  endtask

  initial begin
    rst = 1'b1; tick0 = 1'b0; tick1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    repeat (2) @(posedge clock); #1;
    chk("rst_locked", locked0, 0);
    chk("rst_period", period0, 0);
    chk("rst_err",    {early0, late0}, 0);
    chk("rst_cnt",    err0, 0);
    rst = 1'b0;

    // Lock from reset with single-cycle ticks every 5 clocks
    c0(1); chk("s1_t0_period", period0, 0);
    idle0(4); c0(1);
    chk("s1_t1_period", period0, 5);
    chk("s1_t1_locked", locked0, 0);
    idle0(4); c0(1);
    chk("s1_t2_locked", locked0, 0);
    idle0(4); c0(1);
    chk("s1_t3_locked", locked0, 1);
    chk("s1_t3_period", period0, 5);
    chk("s1_noerr", {early0, late0}, 0);
    chk("s1_cnt", err0, 0);

    // Early tick after 3 clocks, then relock
    idle0(2); c0(1);
    chk("s2_early", early0, 1);
    chk("s2_period", period0, 3);
    chk("s2_locked", locked0, 0);
    chk("s2_cnt", err0, 1);
    c0(0);
    chk("s2_early_1cyc", early0, 0);
    idle0(3); c0(1);
    idle0(4); c0(1);
    chk("s2_relock_2", locked0, 0);
    idle0(4); c0(1);
    chk("s2_relock_3", locked0, 1);

    // Missing tick: late pulse at edge+7 only
    idle0(5);
    chk("s3_t6_late", late0, 0);
    chk("s3_t6_locked", locked0, 1);
    c0(0);
    chk("s3_t7_late", late0, 1);
    chk("s3_t7_locked", locked0, 0);
    chk("s3_t7_period", period0, 5);
    late_seen = 0;
    for (int i = 0; i < 50; i++) begin
      c0(0);
      if (late0 || early0) late_seen++;
    end
    chk("s3_no_repeat", late_seen, 0);
    chk("s3_cnt", err0, 2);

    // Tick held high 3 cycles per period
    for (int k = 0; k < 3; k++) begin
      c0(1);
      if (k == 1) chk("s4_period", period0, 5);
      if (k == 2) chk("s4_locked_2", locked0, 0);
      c0(1); c0(1); c0(0); c0(0);
    end
    c0(1);
    chk("s4_locked_3", locked0, 1);
    chk("s4_cnt", err0, 2);

    // Two more early errors (intervals 3 and 2), then relock
    idle0(2); c0(1);
    chk("s5_early3", early0, 1);
    c0(0); c0(1);
    chk("s5_period2", period0, 2);
    for (int k = 0; k < 3; k++) begin idle0(4); c0(1); end
    chk("s5_locked", locked0, 1);
    chk("s5_cnt", err0, 4);

    // Single-cycle reset while locked
    rst = 1'b1; c0(0); rst = 1'b0;
    chk("s6_locked", locked0, 0);
    chk("s6_period", period0, 0);
    chk("s6_err", {early0, late0}, 0);
    chk("s6_cnt", err0, 0);
    c0(1);
    chk("s6_search_period", period0, 0);
    idle0(4); c0(1);
    chk("s6_acq_period", period0, 5);
    chk("s6_acq_locked", locked0, 0);

    // TOL=1: intervals 4,6,5 accepted, 7 is late (edge wins over timeout)
    c1(1);
    idle1(3); c1(1);
    chk("t1_p4", period1, 4);
    chk("t1_p4_err", {early1, late1}, 0);
    idle1(5); c1(1);
    chk("t1_p6", period1, 6);
    chk("t1_p6_err", {early1, late1}, 0);
    idle1(4); c1(1);
    chk("t1_p5_locked", locked1, 1);
    idle1(6); c1(1);
    chk("t1_p7_late", late1, 1);
    chk("t1_p7_period", period1, 7);
    chk("t1_p7_locked", locked1, 0);
    chk("t1_p7_cnt", err1, 1);

    // Saturate the error counter, then clear behaviour
    for (int i = 0; i < 300; i++) begin c1(0); c1(1); end
    chk("t1_sat_early", early1, 1);
    chk("t1_sat_cnt", err1, 255);
    c1(0);
    clr1 = 1'b1; c1(1); clr1 = 1'b0;
    chk("t1_clr_with_err", err1, 1);
    clr1 = 1'b1; c1(0); clr1 = 1'b0;
    chk("t1_clr_alone", err1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
